// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one producer per cycle
// and registers its result for a one-cycle-latency broadcast.
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*24-1:0] req_data,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  cdb_valid,
   output logic [23:0]           cdb_data,
   output logic [IDX_W-1:0]      cdb_src
);

   // Handshake: a producer transfers in a cycle where its req_valid and
   // req_ready are both high; it drops or replaces its result on the next edge.

   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             cdb_valid_q, cdb_valid_d;
   logic [23:0]      cdb_data_q, cdb_data_d;
   logic [IDX_W-1:0] cdb_src_q, cdb_src_d;

   logic [IDX_W-1:0] grant_idx;
   logic             found;
   logic             grant_en;
   logic             transfer;
   int               scan_idx;

   // Search starts at rr_ptr and wraps, so the most recent winner goes last.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && req_valid[scan_idx]) begin
            found     = 1'b1;
            grant_idx = scan_idx[IDX_W-1:0];
         end
      end
   end

   assign grant_en = found & ~flush & reset_n;

   always_comb begin
      req_ready = '0;
      if (grant_en) req_ready[grant_idx] = 1'b1;
   end

   assign transfer = req_valid[grant_idx] & req_ready[grant_idx];

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = transfer;
      cdb_data_d  = cdb_data_q;
      cdb_src_d   = cdb_src_q;
      if (transfer) begin
         cdb_data_d = req_data[int'(grant_idx)*24 +: 24];
         cdb_src_d  = grant_idx;
         if (grant_idx == IDX_W'(NUM_REQ-1)) rr_ptr_d = '0;
         else                                rr_ptr_d = grant_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_data_q  <= cdb_data_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_data  = cdb_data_q;
   assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: per-cycle table of inputs and
// expected outputs, a broadcast scoreboard, and a starvation sequence.
module tb_cdb_arbiter;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   logic                  clk;
   logic                  reset_n;
   logic                  flush;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*24-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  cdb_valid;
   logic [23:0]           cdb_data;
   logic [IDX_W-1:0]      cdb_src;

   cdb_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cdb_valid (cdb_valid),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        fl;
      logic [3:0]  valid;
      logic [95:0] data;
      logic [3:0]  ready;
      logic        cv;
      logic [23:0] cd;
      logic [1:0]  cs;
      logic [1:0]  rr;
   } vec_t;

   vec_t        vecs[$];
   logic [25:0] exp_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   logic [23:0] sl0, sl1, sl2, sl3, p28, pab;
   logic [95:0] all_d;

   function automatic logic [23:0] pack(input logic [15:0] d, input logic [3:0] q,
                                        input logic [2:0] cc, input logic m);
      return {d, q, cc, m};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic add_vec(input logic rst_n, input logic fl, input logic [3:0] valid,
                          input logic [95:0] data, input logic [3:0] ready, input logic cv,
                          input logic [23:0] cd, input logic [1:0] cs, input logic [1:0] rr);
      vec_t v;
      v.rst_n = rst_n; v.fl = fl; v.valid = valid; v.data = data;
      v.ready = ready; v.cv = cv; v.cd = cd; v.cs = cs; v.rr = rr;
      vecs.push_back(v);
   endtask

   // Driver + checker for one cycle; samples at the falling edge.
   task automatic apply(input vec_t v, input int n);
      logic [25:0] e;
      reset_n   = v.rst_n;
      flush     = v.fl;
      req_valid = v.valid;
      req_data  = v.data;
      #4;
      check($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.ready));
      check($sformatf("v%0d cdb_valid", n), 32'(cdb_valid), 32'(v.cv));
      check($sformatf("v%0d cdb_data", n), 32'(cdb_data), 32'(v.cd));
      check($sformatf("v%0d cdb_src", n), 32'(cdb_src), 32'(v.cs));
      check($sformatf("v%0d rr_ptr", n), 32'(dut.rr_ptr_q), 32'(v.rr));
      if (cdb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL v%0d sb_unexpected: got broadcast src %0d data %0h, expected none",
                     n, cdb_src, cdb_data);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d sb_broadcast", n), 32'({cdb_src, cdb_data}), 32'(e));
         end
      end
      for (int i = 0; i < NUM_REQ; i++)
         if (v.ready[i]) exp_q.push_back({2'(i), v.data[i*24 +: 24]});
      @(posedge clk);
      #1;
   endtask

   initial begin
      sl0 = 24'h1A1A10; sl1 = 24'h2B2B21; sl2 = 24'h3C3C36; sl3 = 24'h4D4D4F;
      all_d = {sl3, sl2, sl1, sl0};
      p28 = pack(16'h1234, 4'h5, 3'h3, 1'b1);   // 24'h123457
      pab = pack(16'hABCD, 4'h9, 3'h2, 1'b0);   // 24'hABCD94

      //       rst fl valid    data                       ready    cv  cdata  src rr
      add_vec(1, 0, 4'b0000, '0,                        4'b0000, 0, 24'h0, 0, 0); // reset state
      add_vec(1, 0, 4'b0100, {24'h0, p28, 48'h0},       4'b0100, 0, 24'h0, 0, 0); // single request
      add_vec(1, 0, 4'b0000, '0,                        4'b0000, 1, p28,   2, 3);
      add_vec(1, 0, 4'b0011, all_d,                     4'b0001, 0, p28,   2, 3); // wrap 3 -> 0
      add_vec(1, 0, 4'b0011, all_d,                     4'b0010, 1, sl0,   0, 1);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 1, sl1,   1, 2);
      add_vec(1, 0, 4'b1000, all_d,                     4'b1000, 0, sl1,   1, 2);
      add_vec(1, 0, 4'b1111, all_d,                     4'b0001, 1, sl3,   3, 0); // all contend
      add_vec(1, 0, 4'b1111, all_d,                     4'b0010, 1, sl0,   0, 1);
      add_vec(1, 0, 4'b1111, all_d,                     4'b0100, 1, sl1,   1, 2);
      add_vec(1, 0, 4'b1111, all_d,                     4'b1000, 1, sl2,   2, 3);
      add_vec(1, 0, 4'b1111, all_d,                     4'b0001, 1, sl3,   3, 0);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 1, sl0,   0, 1);
      add_vec(1, 0, 4'b0010, all_d,                     4'b0010, 0, sl0,   0, 1); // flush: N
      add_vec(1, 1, 4'b0010, all_d,                     4'b0000, 1, sl1,   1, 2); // N+1
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 0, sl1,   1, 2); // N+2
      add_vec(1, 0, 4'b0100, {24'h0, pab, 48'h0},       4'b0100, 0, sl1,   1, 2); // idle after ABCD
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 1, pab,   2, 3);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 0, pab,   2, 3);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 0, pab,   2, 3);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 0, pab,   2, 3);
      add_vec(1, 0, 4'b1111, all_d,                     4'b1000, 0, pab,   2, 3); // reset mid-stream
      add_vec(1, 0, 4'b1111, all_d,                     4'b0001, 1, sl3,   3, 0);
      add_vec(0, 1, 4'b1111, all_d,                     4'b0000, 1, sl0,   0, 1);
      add_vec(1, 0, 4'b1111, all_d,                     4'b0001, 0, 24'h0, 0, 0);
      add_vec(1, 0, 4'b1111, all_d,                     4'b0010, 1, sl0,   0, 1);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 1, sl1,   1, 2);
      add_vec(1, 0, 4'b0000, all_d,                     4'b0000, 0, sl1,   1, 2);

      reset_n   = 1'b0;
      flush     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[n]) apply(vecs[n], n);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      // Producer 0 holds valid while the others toggle; its grant must come within NUM_REQ cycles.
      for (int t = 0; t < 3; t++) begin
         int          waited;
         bit          got;
         logic [2:0]  r;
         waited = 0;
         got    = 1'b0;
         while (!got && waited < NUM_REQ + 2) begin
            r         = 3'($urandom_range(0, 7));
            reset_n   = 1'b1;
            flush     = 1'b0;
            req_valid = {r, 1'b1};
            req_data  = all_d;
            #4;
            waited++;
            check($sformatf("starve%0d onehot", t), 32'($onehot(req_ready)), 32'd1);
            check($sformatf("starve%0d subset", t), 32'(req_ready & ~req_valid), 32'd0);
            if (req_ready[0]) got = 1'b1;
            @(posedge clk);
            #1;
         end
         check($sformatf("starve%0d latency", t), 32'(got && waited <= NUM_REQ), 32'd1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
